// File: rtl/chan_arbiter.sv
// chan_arbiter
//   Round-robin poller for NCH channel output FIFOs sharing one
//   give/have/data bus. It grants one channel at a time and copies exactly one
//   block (a control word holding length L in bits 8:0, then L data words) into
//   a single registered 16-bit output stream. It also checks block framing and
//   closes stalled blocks with a filler word.
//
// Ports
//   clk        125 MHz clock, same as the channel FIFO read clock
//   reset      asynchronous, active-high
//   chmask     per-channel skip mask (1 = channel is never polled)
//   give       one-hot request to the channel; at most one bit is set
//   have       per-channel acknowledge, combinational from give
//   data       shared bus word, valid in the cycle where give&have is set
//   afull      downstream FIFO is nearly full; only blocks new grants
//   dout       output word
//   dvalid     dout write strobe (one clock after the word was taken)
//   blk_done   1-clk pulse with the last word of a good block
//   err_frame  1-clk pulse on a framing error
//   err_tmo    1-clk pulse when a block stalls for 2**TMOBITS-1 clocks
//   cur_ch     channel currently granted, zero-extended (0 while idle)
module chan_arbiter #(
  parameter int unsigned NCH     = 16,
  parameter int unsigned TMOBITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    chmask,
  output logic [NCH-1:0]    give,
  input  logic [NCH-1:0]    have,
  input  logic [15:0]       data,
  input  logic              afull,
  output logic [15:0]       dout,
  output logic              dvalid,
  output logic              blk_done,
  output logic              err_frame,
  output logic              err_tmo,
  output logic [5:0]        cur_ch
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  // Last stalled cycle before the timeout fires: count runs 0 .. 2**TMOBITS-2.
  localparam logic [TMOBITS-1:0] TMO_LAST = {{(TMOBITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {ST_SEL, ST_CW, ST_DATA} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [8:0]           rem_q, rem_d;
  logic [TMOBITS-1:0]   tmo_q, tmo_d;
  logic [15:0]          dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 blk_done_q, blk_done_d;
  logic                 err_frame_q, err_frame_d;
  logic                 err_tmo_q, err_tmo_d;

  logic [PW-1:0]        ptr_inc;
  logic                 have_cur;
  logic                 mask_cur;

  assign ptr_inc  = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + 1'b1;
  assign have_cur = have[ptr_q];
  assign mask_cur = chmask[ptr_q];

  // give and cur_ch are decoded straight from the state register, so they
  // clear together with it on reset and never glitch against have.
  always_comb begin
    give   = '0;
    cur_ch = '0;
    if (state_q != ST_SEL) begin
      give[ptr_q] = 1'b1;
      cur_ch      = 6'(ptr_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    blk_done_d  = 1'b0;
    err_frame_d = 1'b0;
    err_tmo_d   = 1'b0;
    case (state_q)
      ST_SEL: begin
        if (!afull) begin
          if (mask_cur) ptr_d   = ptr_inc;
          else          state_d = ST_CW;
        end
      end
      ST_CW: begin
        if (!have_cur) begin
          ptr_d   = ptr_inc;
          state_d = ST_SEL;
        end else if (data[15]) begin
          dout_d   = data;
          dvalid_d = 1'b1;
          rem_d    = data[8:0];
          tmo_d    = '0;
          if (data[8:1] == '0) begin
            // L of 0 or 1 cannot frame a block: pass it on, flag it, move on.
            err_frame_d = 1'b1;
            ptr_d       = ptr_inc;
            state_d     = ST_SEL;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          // Stray data word while hunting for a control word: it is consumed
          // by the bus anyway, so drop it and keep draining this channel.
          err_frame_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (have_cur) begin
          dout_d      = {1'b0, data[14:0]};
          dvalid_d    = 1'b1;
          err_frame_d = data[15];
          rem_d       = rem_q - 1'b1;
          tmo_d       = '0;
          if (rem_q == 9'd1) begin
            blk_done_d = 1'b1;
            ptr_d      = ptr_inc;
            state_d    = ST_SEL;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          dout_d    = 16'h7FFF;
          dvalid_d  = 1'b1;
          ptr_d     = ptr_inc;
          state_d   = ST_SEL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_SEL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SEL;
      ptr_q       <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      blk_done_q  <= 1'b0;
      err_frame_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      tmo_q       <= tmo_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      blk_done_q  <= blk_done_d;
      err_frame_q <= err_frame_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign dout      = dout_q;
  assign dvalid    = dvalid_q;
  assign blk_done  = blk_done_q;
  assign err_frame = err_frame_q;
  assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_chan_arbiter.sv
// tb_chan_arbiter
//   Scoreboard bench for chan_arbiter. Each channel is a small bench-side FIFO
//   that answers have combinationally while granted and pops on the clock edge.
//   The stimulus process loads FIFOs and queues the expected output events;
//   the monitor process pops and compares every output event and every queued
//   timing measurement.
module tb_chan_arbiter;

  localparam int NCH = 16;

  typedef struct packed {
    logic        dv;
    logic [15:0] d;
    logic        bd;
    logic        ef;
    logic        et;
  } ev_t;

  typedef struct {
    int id;
    int act;
    int exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] chmask = '0;
  logic [15:0] give;
  logic [15:0] have;
  logic [15:0] data;
  logic        afull = 1'b0;
  logic [15:0] dout;
  logic        dvalid;
  logic        blk_done;
  logic        err_frame;
  logic        err_tmo;
  logic [5:0]  cur_ch;

  logic [15:0] mem [NCH][64];
  int unsigned wp [NCH];
  int unsigned rp [NCH] = '{default: 0};
  int unsigned give_cnt [NCH] = '{default: 0};
  int unsigned cyc = 0;
  int unsigned any_give_cnt = 0;
  int unsigned stall1_cnt = 0;

  ev_t  exp_q [$];
  chk_t chk_q [$];
  bit   sb_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  chan_arbiter #(.NCH(16), .TMOBITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .chmask    (chmask),
    .give      (give),
    .have      (have),
    .data      (data),
    .afull     (afull),
    .dout      (dout),
    .dvalid    (dvalid),
    .blk_done  (blk_done),
    .err_frame (err_frame),
    .err_tmo   (err_tmo),
    .cur_ch    (cur_ch)
  );

  always #4 clk = ~clk;

  // Channel FIFOs on the shared bus.
  always_comb begin
    have = '0;
    data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (give[i] && rp[i] != wp[i]) begin
        have[i] = 1'b1;
        data    = mem[i][rp[i] % 64];
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (give != '0) any_give_cnt <= any_give_cnt + 1;
    if (give[1] && !have[1]) stall1_cnt <= stall1_cnt + 1;
    for (int i = 0; i < NCH; i++) begin
      if (have[i]) rp[i] <= rp[i] + 1;
      if (give[i]) give_cnt[i] <= give_cnt[i] + 1;
    end
  end

  function automatic string cname(input int id);
    case (id)
      0:  return "give3_cycles";
      1:  return "gap_ch0_to_ch5";
      2:  return "gap_ch5_to_ch15";
      3:  return "afull_hold_give";
      4:  return "afull_release_sel";
      5:  return "afull_release_grant";
      6:  return "afull_release_cur_ch";
      7:  return "tmo_stall_len";
      8:  return "tmo_give_drop";
      9:  return "masked_ch7_untouched";
      10: return "rst_async_give";
      11: return "rst_async_dvalid";
      12: return "rst_async_cur_ch";
      13: return "rst_async_dout";
      14: return "rst_restart_give";
      15: return "rst_restart_cur_ch";
      16: return "wait_budget";
      17: return "drain_budget";
      18: return "reset_give";
      19: return "reset_dvalid";
      20: return "reset_flags";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    chk_t c;
    ev_t  a;
    ev_t  e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act != c.exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", cname(c.id), c.act, c.exp);
      end
    end
    if (sb_en && !reset) begin
      if (give != '0) begin
        checks++;
        if (give != (16'd1 << cur_ch)) begin
          failures++;
          $display("FAIL grant_onehot: give=%h cur_ch=%0d", give, cur_ch);
        end
      end
      if (dvalid || blk_done || err_frame || err_tmo) begin
        a = '{dv: dvalid, d: dout, bd: blk_done, ef: err_frame, et: err_tmo};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got dv=%b d=%h bd=%b ef=%b et=%b expected none",
                   a.dv, a.d, a.bd, a.ef, a.et);
        end else begin
          e = exp_q.pop_front();
          if (a.dv != e.dv || (e.dv && a.d != e.d) || a.bd != e.bd ||
              a.ef != e.ef || a.et != e.et) begin
            failures++;
            $display("FAIL out_event: got dv=%b d=%h bd=%b ef=%b et=%b expected dv=%b d=%h bd=%b ef=%b et=%b",
                     a.dv, a.d, a.bd, a.ef, a.et, e.dv, e.d, e.bd, e.ef, e.et);
          end
        end
      end
    end
  end

  task automatic check(input int id, input int act, input int exp);
    chk_q.push_back('{id: id, act: act, exp: exp});
  endtask

  task automatic put(input int ch, input logic [15:0] w);
    mem[ch][wp[ch] % 64] = w;
    wp[ch]++;
  endtask

  task automatic exp_ev(input bit dv, input logic [15:0] d, input bit bd, input bit ef, input bit et);
    exp_q.push_back('{dv: dv, d: d, bd: bd, ef: ef, et: et});
  endtask

  // A well-formed block: control word then L data words base+1 .. base+L.
  task automatic exp_block(input int ch, input logic [15:0] cw, input logic [15:0] base);
    int n;
    n = int'(cw[8:0]);
    put(ch, cw);
    exp_ev(1'b1, cw, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      put(ch, base + 16'(k));
      exp_ev(1'b1, base + 16'(k), k == n, 1'b0, 1'b0);
    end
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return blk_done;
      1: return dvalid;
      2: return err_tmo;
      default: return give != '0;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(kind) && n < budget);
    if (!cond(kind)) check(16, kind, -1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check(17, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset  = 1'b1;
    afull  = 1'b0;
    chmask = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned snap;
    int c0;
    for (int i = 0; i < NCH; i++) wp[i] = 0;

    // Reset state
    #1;
    check(18, int'(give), 0);
    check(19, int'(dvalid), 0);
    check(20, int'({dout, blk_done, err_frame, err_tmo, cur_ch}), 0);
    sb_en = 1'b1;

    // Single block on channel 3
    enter_reset();
    exp_block(3, 16'h8605, 16'h1100);
    snap = give_cnt[3];
    reset = 1'b0;
    wait_for(0, 100);
    check(0, int'(give_cnt[3] - snap), 6);
    wait_drain(200);

    // Channels 0, 5, 15 with L=3 blocks; ch15 carries a stray bit15 data word
    enter_reset();
    exp_block(0, 16'h8003, 16'h2000);
    exp_block(5, 16'h8003, 16'h2500);
    put(15, 16'h8003); exp_ev(1, 16'h8003, 0, 0, 0);
    put(15, 16'h2F01); exp_ev(1, 16'h2F01, 0, 0, 0);
    put(15, 16'hAF02); exp_ev(1, 16'h2F02, 0, 1, 0);
    put(15, 16'h2F03); exp_ev(1, 16'h2F03, 1, 0, 0);
    reset = 1'b0;
    wait_for(0, 100);
    c0 = int'(cyc);
    wait_for(1, 100);
    check(1, int'(cyc) - c0, 10);
    wait_for(0, 100);
    c0 = int'(cyc);
    wait_for(1, 100);
    check(2, int'(cyc) - c0, 20);
    wait_drain(200);

    // afull raised together with ch1's blk_done holds the ch2 grant
    enter_reset();
    exp_block(1, 16'h8002, 16'h3100);
    exp_block(2, 16'h8003, 16'h3200);
    reset = 1'b0;
    wait_for(0, 100);
    afull = 1'b1;
    snap = any_give_cnt;
    repeat (20) @(negedge clk);
    check(3, int'(any_give_cnt - snap), 0);
    @(posedge clk);
    #1 afull = 1'b0;
    @(negedge clk);
    check(4, int'(give), 0);
    @(negedge clk);
    check(5, int'(give), 4);
    check(6, int'(cur_ch), 2);
    wait_drain(200);

    // Mid-block stall on ch1, then the tail arrives late as stray words
    enter_reset();
    put(1, 16'h8005); exp_ev(1, 16'h8005, 0, 0, 0);
    put(1, 16'h4111); exp_ev(1, 16'h4111, 0, 0, 0);
    put(1, 16'h4112); exp_ev(1, 16'h4112, 0, 0, 0);
    exp_ev(1, 16'h7FFF, 0, 0, 1);
    exp_block(2, 16'h8002, 16'h4200);
    snap = stall1_cnt;
    reset = 1'b0;
    wait_for(2, 400);
    check(7, int'(stall1_cnt - snap), 255);
    check(8, int'(give), 0);
    repeat (45) @(negedge clk);
    put(1, 16'h4113); exp_ev(0, 16'h0000, 0, 1, 0);
    put(1, 16'h4114); exp_ev(0, 16'h0000, 0, 1, 0);
    put(1, 16'h4115); exp_ev(0, 16'h0000, 0, 1, 0);
    wait_drain(200);

    // Framing: stray word before CW on ch4, L=1 CW on ch6, masked ch7
    enter_reset();
    chmask = 16'h0080;
    put(4, 16'h0123); exp_ev(0, 16'h0000, 0, 1, 0);
    exp_block(4, 16'h8003, 16'h5000);
    put(6, 16'h8001); exp_ev(1, 16'h8001, 0, 1, 0);
    put(7, 16'h8002);
    put(7, 16'h5701);
    put(7, 16'h5702);
    snap = rp[7];
    reset = 1'b0;
    wait_drain(200);
    check(9, int'(rp[7] - snap), 0);
    exp_ev(1, 16'h8002, 0, 0, 0);
    exp_ev(1, 16'h5701, 0, 0, 0);
    exp_ev(1, 16'h5702, 1, 0, 0);
    chmask = '0;
    wait_drain(200);

    // Asynchronous reset during word 3 of an L=10 block on ch3
    enter_reset();
    sb_en = 1'b0;
    put(3, 16'h800A);
    for (int k = 1; k <= 10; k++) put(3, 16'h6300 + 16'(k));
    snap = rp[3];
    reset = 1'b0;
    for (int n = 0; n < 60 && rp[3] - snap < 3; n++) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check(10, int'(give), 0);
    check(11, int'(dvalid), 0);
    check(12, int'(cur_ch), 0);
    check(13, int'(dout), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_for(3, 50);
    check(14, int'(give), 1);
    check(15, int'(cur_ch), 0);
    repeat (80) @(negedge clk);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
